acia_fifo_ctrl: RTL and testbench

Polling controller that owns the ACIA register port and decouples it from the rest of the system through two byte FIFOs. It initialises the ACIA after reset, then repeatedly reads the status register, drains received bytes into the RX FIFO, and feeds bytes from the TX FIFO into the ACIA data register whenever the transmitter is empty. It sits between the ACIA and any byte-stream client, such as a debug monitor or a bridge, so that client never handles the ACIA status and data protocol itself.

---
 rtl/acia_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_acia_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_fifo_ctrl.sv
// Polling controller for an ACIA register port: initialises the ACIA, then
// moves received bytes into an RX FIFO and TX FIFO bytes into the transmitter.
module acia_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  input  logic       err_clr,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout
);

  typedef enum logic [2:0] {
    RST   = 3'd0,
    INIT0 = 3'd1,
    INIT1 = 3'd2,
    POLL  = 3'd3,
    PCAP  = 3'd4,
    RXRD  = 3'd5,
    RXCAP = 3'd6,
    TXWR  = 3'd7
  } state_e;

  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  state_e      state_q, state_d;
  logic        rx_err_q, rx_err_d;

  logic [7:0]  tx_mem_q [DEPTH];
  logic [7:0]  rx_mem_q [DEPTH];
  logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        sts_rx_full, sts_tx_empty, sts_err;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);

  assign tx_push = tx_valid && !tx_full;
  assign tx_pop  = (state_q == TXWR);
  assign rx_push = (state_q == RXCAP);
  assign rx_pop  = rx_ready && !rx_empty;

  assign tx_wp_d = tx_push ? tx_wp_q + PTR_INC : tx_wp_q;
  assign tx_rp_d = tx_pop  ? tx_rp_q + PTR_INC : tx_rp_q;
  assign rx_wp_d = rx_push ? rx_wp_q + PTR_INC : rx_wp_q;
  assign rx_rp_d = rx_pop  ? rx_rp_q + PTR_INC : rx_rp_q;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_mem_q[rx_rp_q[AW-1:0]];
  assign rx_err   = rx_err_q;

  assign sts_rx_full  = acia_dout[0];
  assign sts_tx_empty = acia_dout[1];
  assign sts_err      = acia_dout[4] | acia_dout[5];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= acia_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST;
      rx_err_q <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
    end else begin
      state_q  <= state_d;
      rx_err_q <= rx_err_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
    end
  end

  // A newly sampled error overrides a clear in the same cycle.
  always_comb begin
    rx_err_d = rx_err_q;
    if (err_clr) rx_err_d = 1'b0;
    if (state_q == PCAP && sts_err) rx_err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:   state_d = INIT0;
      INIT0: state_d = INIT1;
      INIT1: state_d = POLL;
      POLL:  state_d = PCAP;
      PCAP: begin
        if (sts_rx_full && !rx_full)       state_d = RXRD;
        else if (sts_tx_empty && !tx_empty) state_d = TXWR;
        else                                state_d = POLL;
      end
      RXRD:  state_d = RXCAP;
      RXCAP: state_d = POLL;
      TXWR:  state_d = POLL;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    acia_cs  = 1'b0;
    acia_we  = 1'b0;
    acia_rs  = 1'b0;
    acia_din = 8'h00;
    case (state_q)
      INIT0: begin
        acia_cs  = 1'b1;
        acia_we  = 1'b1;
        acia_din = 8'h03;
      end
      INIT1: begin
        acia_cs = 1'b1;
        acia_we = 1'b1;
      end
      POLL: acia_cs = 1'b1;
      RXRD: begin
        acia_cs = 1'b1;
        acia_rs = 1'b1;
      end
      TXWR: begin
        acia_cs  = 1'b1;
        acia_we  = 1'b1;
        acia_rs  = 1'b1;
        acia_din = tx_mem_q[tx_rp_q[AW-1:0]];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acia_fifo_ctrl.sv
// Bench for acia_fifo_ctrl: behavioural ACIA model plus TX/RX scoreboards.
module tb_acia_fifo_ctrl;
  localparam int DEPTH  = 16;
  localparam int TX_DLY = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       err_clr;
  logic       acia_cs, acia_we, acia_rs;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;

  acia_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_err(rx_err), .err_clr(err_clr),
    .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
    .acia_din(acia_din), .acia_dout(acia_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] m_rx_src[$];

  logic       m_rx_full  = 1'b0;
  logic       m_tx_empty = 1'b1;
  logic       m_stall    = 1'b0;
  logic [1:0] m_err      = 2'b00;
  logic [7:0] m_rx_byte  = 8'h00;
  int         m_tx_cnt   = 0;

  int n_tx_wr = 0, n_rx_rd = 0, n_rx_pop = 0;
  int last_poll_cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0, rd_poll_cyc = 0;

  logic [10:0] smp_bus;
  logic        smp_tx_ready, smp_rx_valid, smp_rx_err;
  logic [7:0]  smp_rx_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe the bus at negedge, update the ACIA model, and
  // present registered read data just after the following posedge.
  task automatic tick();
    logic [7:0] nd;
    logic       upd;
    upd = 1'b0;
    nd  = acia_dout;
    @(negedge clk);
    cyc++;
    smp_bus      = {acia_cs, acia_we, acia_rs, acia_din};
    smp_tx_ready = tx_ready;
    smp_rx_valid = rx_valid;
    smp_rx_err   = rx_err;
    smp_rx_data  = rx_data;
    if (acia_cs && !acia_we) begin
      upd = 1'b1;
      if (acia_rs) begin
        n_rx_rd++;
        last_rd_cyc = cyc;
        rd_poll_cyc = last_poll_cyc;
        nd = m_rx_byte;
        m_rx_full = 1'b0;
      end else begin
        last_poll_cyc = cyc;
        nd = m_stall ? {2'b00, m_err, 4'h0} : {2'b00, m_err, 2'b00, m_tx_empty, m_rx_full};
      end
    end
    if (acia_cs && acia_we && acia_rs) begin
      n_tx_wr++;
      last_wr_cyc = cyc;
      chk("tx_wr_while_busy", m_tx_empty, 1);
      chk("tx_wr_pending", tx_exp.size() > 0, 1);
      if (tx_exp.size() > 0) chk("tx_wr_data", acia_din, tx_exp.pop_front());
      m_tx_empty = 1'b0;
      m_tx_cnt   = TX_DLY;
    end else if (m_tx_cnt > 0) begin
      m_tx_cnt--;
      if (m_tx_cnt == 0) m_tx_empty = 1'b1;
    end
    if (tx_valid && tx_ready) tx_exp.push_back(tx_data);
    if (rx_valid && rx_ready) begin
      n_rx_pop++;
      chk("rx_pop_pending", rx_exp.size() > 0, 1);
      if (rx_exp.size() > 0) chk("rx_data", rx_data, rx_exp.pop_front());
    end
    if (!m_rx_full && m_rx_src.size() > 0) begin
      m_rx_byte = m_rx_src.pop_front();
      m_rx_full = 1'b1;
      rx_exp.push_back(m_rx_byte);
    end
    @(posedge clk);
    #1;
    if (upd) acia_dout = nd;
  endtask

  task automatic check_init();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_bus", smp_bus, 0);
    chk("rst_tx_ready", smp_tx_ready, 1);
    chk("rst_rx_valid", smp_rx_valid, 0);
    chk("rst_rx_err", smp_rx_err, 0);
    rst = 1'b0;
    tick(); chk("init_rst_state", smp_bus, 0);
    tick(); chk("init0_write", smp_bus, {3'b110, 8'h03});
    tick(); chk("init1_write", smp_bus, {3'b110, 8'h00});
    tick(); chk("first_poll", smp_bus, {3'b100, 8'h00});
    tick(); chk("first_pcap", smp_bus, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rd0, wr0, pop0;
    logic rdy_low;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    err_clr   = 1'b0;
    acia_dout = 8'h00;

    check_init();
    for (int i = 0; i < 3; i++) begin
      tick(); chk("idle_poll", smp_bus, {3'b100, 8'h00});
      tick(); chk("idle_pcap", smp_bus, 0);
    end

    // Two TX bytes
    wr0 = n_tx_wr;
    rdy_low = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h55; tick();
    if (!smp_tx_ready) rdy_low = 1'b1;
    tx_data = 8'hA3; tick();
    if (!smp_tx_ready) rdy_low = 1'b1;
    tx_valid = 1'b0;
    for (int i = 0; i < 80 && (n_tx_wr - wr0) < 2; i++) begin
      tick();
      if (!smp_tx_ready) rdy_low = 1'b1;
    end
    chk("tx_two_writes", n_tx_wr - wr0, 2);
    chk("tx_ready_held", rdy_low, 0);
    chk("tx_all_sent", tx_exp.size(), 0);

    // Single RX byte
    m_rx_src.push_back(8'h7E);
    for (int i = 0; i < 40 && !smp_rx_valid; i++) tick();
    chk("rx_valid_up", smp_rx_valid, 1);
    chk("rx_head", smp_rx_data, 8'h7E);
    chk("rx_rd_latency", last_rd_cyc - rd_poll_cyc, 2);
    chk("rx_valid_latency", cyc - rd_poll_cyc, 4);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    tick();
    chk("rx_valid_cleared", smp_rx_valid, 0);

    // Fill RX FIFO, one extra byte waits in the ACIA
    rd0  = n_rx_rd;
    pop0 = n_rx_pop;
    for (int i = 0; i <= DEPTH; i++) m_rx_src.push_back(8'h20 + i[7:0]);
    for (int i = 0; i < 400 && (n_rx_rd - rd0) < DEPTH; i++) tick();
    for (int i = 0; i < 40; i++) tick();
    chk("rx_reads_when_full", n_rx_rd - rd0, DEPTH);
    chk("rx_full_valid", smp_rx_valid, 1);
    chk("acia_byte_pending", m_rx_full, 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    for (int i = 0; i < 40 && (n_rx_rd - rd0) < DEPTH + 1; i++) tick();
    chk("rx_read_after_pop", n_rx_rd - rd0, DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) m_rx_src.push_back(8'hC0 ^ i[7:0]);
    rx_ready = 1'b1;
    for (int i = 0; i < 600 && (rx_exp.size() > 0 || m_rx_src.size() > 0 || smp_rx_valid); i++) tick();
    rx_ready = 1'b0;
    chk("rx_drained", rx_exp.size(), 0);
    chk("rx_pop_count", n_rx_pop - pop0, 2 * DEPTH + 1);

    // RX and TX both pending: RX is serviced first
    for (int i = 0; i < 10; i++) tick();
    m_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tx_valid = 1'b1; tx_data = 8'hC4;
    m_rx_src.push_back(8'h3B);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rd0 = n_rx_rd;
    wr0 = n_tx_wr;
    m_stall = 1'b0;
    for (int i = 0; i < 40 && n_tx_wr == wr0; i++) tick();
    chk("prio_rd_seen", n_rx_rd - rd0, 1);
    chk("prio_wr_seen", n_tx_wr - wr0, 1);
    chk("prio_rd_to_wr", last_wr_cyc - last_rd_cyc, 4);
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_exp.size() > 0; i++) tick();
    rx_ready = 1'b0;
    chk("prio_rx_drained", rx_exp.size(), 0);

    // Sticky error, clear, and set-wins-over-clear
    m_err = 2'b10;
    for (int i = 0; i < 20 && !smp_rx_err; i++) tick();
    chk("err_set", smp_rx_err, 1);
    m_err = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    chk("err_sticky", smp_rx_err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tick();
    chk("err_cleared", smp_rx_err, 0);
    err_clr = 1'b1;
    m_err = 2'b01;
    for (int i = 0; i < 20 && !smp_rx_err; i++) tick();
    chk("err_set_wins", smp_rx_err, 1);
    m_err = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    err_clr = 1'b0;
    tick();
    chk("err_clr_held", smp_rx_err, 0);

    // Reset while in TXWR with three bytes queued
    for (int i = 0; i < 10; i++) tick();
    m_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h90 + i[7:0];
      tick();
    end
    tx_valid = 1'b0;
    m_stall = 1'b0;
    for (int i = 0; i < 40 && !(acia_cs && acia_we && acia_rs); i++) tick();
    chk("txwr_reached", acia_cs && acia_we && acia_rs, 1);
    check_init();
    tx_exp.delete();
    wr0 = n_tx_wr;
    for (int i = 0; i < 40; i++) tick();
    chk("no_stale_wr", n_tx_wr - wr0, 0);
    chk("post_rst_tx_ready", smp_tx_ready, 1);
    chk("post_rst_rx_valid", smp_rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
